// File: rtl/int_ctl.sv
// Interrupt, reset and halt sequencer for the 65C02 core: arbitrates reset/NMI/IRQ/BRK
// at opcode fetch, drives the BRK-sequence controls, and implements the WAI/STP halt states.
module int_ctl (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic       sync,
  input  logic [7:0] DB,
  input  logic       nmi,
  input  logic       irq,
  input  logic       I,
  input  logic       vec_done,
  output logic       force_brk,
  output logic [7:0] vector,
  output logic       B,
  output logic       we_mask,
  output logic       set_i,
  output logic       clr_d,
  output logic       halt,
  output logic [1:0] int_src
);

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_RUN  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_STOP = 3'd4
  } state_t;

  localparam logic [1:0] SRC_BRK = 2'd0;
  localparam logic [1:0] SRC_IRQ = 2'd1;
  localparam logic [1:0] SRC_NMI = 2'd2;
  localparam logic [1:0] SRC_RST = 2'd3;

  state_t     state_r;
  logic       nmi1_r;
  logic       nmi_pend_r;
  logic       acc_s;
  logic       nmi_edge_s;
  logic       sel_s;
  logic       force_s;
  logic       take_nmi_s;
  logic       go_wait_s;
  logic       go_stop_s;
  logic [1:0] src_s;

  assign acc_s      = sync & rdy;
  assign nmi_edge_s = nmi & ~nmi1_r;
  assign force_brk  = force_s & ~reset;

  // Opcode-fetch arbitration: first matching source in priority order wins
  always_comb begin
    sel_s      = 1'b0;
    force_s    = 1'b0;
    take_nmi_s = 1'b0;
    go_wait_s  = 1'b0;
    go_stop_s  = 1'b0;
    src_s      = SRC_BRK;
    case (state_r)
      ST_RST: begin
        if (acc_s) begin
          sel_s   = 1'b1;
          force_s = 1'b1;
          src_s   = SRC_RST;
        end else begin
          sel_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (!acc_s) begin
          sel_s = 1'b0;
        end else if (nmi_pend_r) begin
          sel_s      = 1'b1;
          force_s    = 1'b1;
          take_nmi_s = 1'b1;
          src_s      = SRC_NMI;
        end else if (irq && !I) begin
          sel_s   = 1'b1;
          force_s = 1'b1;
          src_s   = SRC_IRQ;
        end else if (DB == 8'h00) begin
          sel_s = 1'b1;
          src_s = SRC_BRK;
        end else if (DB == 8'hCB) begin
          go_wait_s = 1'b1;
        end else if (DB == 8'hDB) begin
          go_stop_s = 1'b1;
        end else begin
          sel_s = 1'b0;
        end
      end
      default: sel_s = 1'b0;
    endcase
  end

  // BRK-sequence controls; reset forces the reset-vector view regardless of state
  always_comb begin
    vector  = 8'hFE;
    B       = 1'b0;
    we_mask = 1'b0;
    if (reset || state_r == ST_RST) begin
      vector  = 8'hFC;
      we_mask = 1'b1;
    end else if (state_r == ST_SEQ) begin
      case (int_src)
        SRC_BRK: B       = 1'b1;
        SRC_NMI: vector  = 8'hFA;
        SRC_RST: begin
          vector  = 8'hFC;
          we_mask = 1'b1;
        end
        default: vector = 8'hFE;
      endcase
    end else begin
      vector = 8'hFE;
    end
  end

  // State, NMI edge latch and registered pulse/halt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RST;
      int_src    <= SRC_RST;
      halt       <= 1'b0;
      set_i      <= 1'b0;
      clr_d      <= 1'b0;
      nmi1_r     <= 1'b0;
      nmi_pend_r <= 1'b0;
    end else begin
      nmi1_r     <= nmi;
      // a fresh edge in the same cycle as selection must not be lost
      nmi_pend_r <= nmi_edge_s | (nmi_pend_r & ~take_nmi_s);
      set_i      <= 1'b0;
      clr_d      <= 1'b0;
      case (state_r)
        ST_RST, ST_RUN: begin
          if (sel_s) begin
            int_src <= src_s;
            state_r <= ST_SEQ;
          end else if (go_wait_s) begin
            state_r <= ST_WAIT;
            halt    <= 1'b1;
          end else if (go_stop_s) begin
            state_r <= ST_STOP;
            halt    <= 1'b1;
          end
        end
        ST_SEQ: begin
          if (vec_done && rdy) begin
            set_i   <= 1'b1;
            clr_d   <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_WAIT: begin
          if (nmi_pend_r || irq) begin
            state_r <= ST_RUN;
            halt    <= 1'b0;
          end
        end
        ST_STOP: state_r <= ST_STOP;
        default: begin
          state_r <= ST_RST;
          halt    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctl.sv
// Scoreboard bench for int_ctl: expectations are queued as stimulus is driven and
// compared at the following falling edge.
module tb_int_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rdy = 1'b1;
  logic       sync = 1'b0;
  logic [7:0] DB = 8'hEA;
  logic       nmi = 1'b0;
  logic       irq = 1'b0;
  logic       I = 1'b1;
  logic       vec_done = 1'b0;
  logic       force_brk;
  logic [7:0] vector;
  logic       B;
  logic       we_mask;
  logic       set_i;
  logic       clr_d;
  logic       halt;
  logic [1:0] int_src;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    string      tag;
    int         id;
    logic [7:0] val;
  } exp_t;
  exp_t sb_q[$];

  int_ctl dut (
    .clk(clk), .reset(reset), .rdy(rdy), .sync(sync), .DB(DB), .nmi(nmi),
    .irq(irq), .I(I), .vec_done(vec_done), .force_brk(force_brk),
    .vector(vector), .B(B), .we_mask(we_mask), .set_i(set_i), .clr_d(clr_d),
    .halt(halt), .int_src(int_src)
  );

  always #5 clk = ~clk;

  localparam int O_FB = 0, O_VEC = 1, O_B = 2, O_WM = 3, O_SI = 4, O_CD = 5, O_HALT = 6, O_SRC = 7;

  function automatic logic [7:0] obs(int id);
    case (id)
      O_FB:    return {7'd0, force_brk};
      O_VEC:   return vector;
      O_B:     return {7'd0, B};
      O_WM:    return {7'd0, we_mask};
      O_SI:    return {7'd0, set_i};
      O_CD:    return {7'd0, clr_d};
      O_HALT:  return {7'd0, halt};
      O_SRC:   return {6'd0, int_src};
      default: return 8'hEE;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [7:0] got, logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  task automatic push(string tag, int id, logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // compare everything queued for this cycle, then advance one clock
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs(e.id), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_seq(string tag);
    sync = 1'b0;
    vec_done = 1'b1;
    push({tag, "_si_before"}, O_SI, 8'd0);
    cyc();
    vec_done = 1'b0;
    push({tag, "_set_i"}, O_SI, 8'd1);
    push({tag, "_clr_d"}, O_CD, 8'd1);
    push({tag, "_run_wm"}, O_WM, 8'd0);
    push({tag, "_run_vec"}, O_VEC, 8'hFE);
    cyc();
    push({tag, "_si_drop"}, O_SI, 8'd0);
    cyc();
  endtask

  task automatic fetch(logic [7:0] op);
    sync = 1'b1;
    DB = op;
  endtask

  initial begin
    // reset state
    @(posedge clk);
    #1;
    push("rst_fb", O_FB, 8'd0);     push("rst_vec", O_VEC, 8'hFC);
    push("rst_b", O_B, 8'd0);       push("rst_wm", O_WM, 8'd1);
    push("rst_src", O_SRC, 8'd3);   push("rst_halt", O_HALT, 8'd0);
    push("rst_si", O_SI, 8'd0);     push("rst_cd", O_CD, 8'd0);
    fetch(8'hA9);
    push("rst_hold_fb", O_FB, 8'd0);
    cyc();
    cyc();

    // reset sequence on first fetch
    reset = 1'b0;
    push("rseq_fb", O_FB, 8'd1);    push("rseq_vec", O_VEC, 8'hFC);
    cyc();
    sync = 1'b0;
    push("rseq_src", O_SRC, 8'd3);  push("rseq_wm", O_WM, 8'd1);
    push("rseq_b", O_B, 8'd0);
    cyc();
    finish_seq("rseq");

    // NMI edge one cycle before acc, with IRQ also asserted
    irq = 1'b1; I = 1'b0; nmi = 1'b1;
    cyc();
    fetch(8'hEA);
    push("nmi_fb", O_FB, 8'd1);
    cyc();
    sync = 1'b0;
    push("nmi_vec", O_VEC, 8'hFA);  push("nmi_src", O_SRC, 8'd2);
    push("nmi_b", O_B, 8'd0);
    cyc();
    finish_seq("nmi");
    fetch(8'hEA);
    push("irq_after_nmi_fb", O_FB, 8'd1);
    cyc();
    sync = 1'b0;
    push("irq_vec", O_VEC, 8'hFE);  push("irq_b", O_B, 8'd0);
    push("irq_src", O_SRC, 8'd1);
    cyc();
    finish_seq("irq");
    irq = 1'b0; I = 1'b1;
    fetch(8'hEA);
    push("nmi_cleared_fb", O_FB, 8'd0);
    cyc();
    nmi = 1'b0;

    // BRK opcode, then BRK with IRQ pending
    fetch(8'h00);
    push("brk_fb", O_FB, 8'd0);
    cyc();
    sync = 1'b0;
    push("brk_src", O_SRC, 8'd0);   push("brk_b", O_B, 8'd1);
    push("brk_vec", O_VEC, 8'hFE);  push("brk_wm", O_WM, 8'd0);
    cyc();
    finish_seq("brk");
    irq = 1'b1; I = 1'b0;
    fetch(8'h00);
    push("brkirq_fb", O_FB, 8'd1);
    cyc();
    sync = 1'b0;
    push("brkirq_src", O_SRC, 8'd1); push("brkirq_b", O_B, 8'd0);
    cyc();
    irq = 1'b0;
    finish_seq("brkirq");

    // WAI with I=1: wake on irq, no interrupt taken
    I = 1'b1;
    fetch(8'hCB);
    push("wai_fb", O_FB, 8'd0);     push("wai_halt_pre", O_HALT, 8'd0);
    cyc();
    sync = 1'b0;
    push("wai_halt", O_HALT, 8'd1);
    cyc();
    irq = 1'b1;
    push("wai_halt_hold", O_HALT, 8'd1);
    cyc();
    fetch(8'hEA);
    push("wai_wake_halt", O_HALT, 8'd0); push("wai_masked_fb", O_FB, 8'd0);
    cyc();
    irq = 1'b0; sync = 1'b0;

    // WAI with I=0: wake and take IRQ
    I = 1'b0;
    fetch(8'hCB);
    cyc();
    sync = 1'b0; irq = 1'b1;
    push("wai2_halt", O_HALT, 8'd1);
    cyc();
    fetch(8'hEA);
    push("wai2_halt_off", O_HALT, 8'd0); push("wai2_fb", O_FB, 8'd1);
    cyc();
    sync = 1'b0; irq = 1'b0;
    push("wai2_src", O_SRC, 8'd1);
    cyc();
    finish_seq("wai2");

    // STP: immune to nmi/irq/fetches, only reset exits
    I = 1'b1;
    fetch(8'hDB);
    cyc();
    sync = 1'b0; nmi = 1'b1; irq = 1'b1;
    push("stp_halt", O_HALT, 8'd1);
    cyc();
    nmi = 1'b0;
    cyc();
    nmi = 1'b1;
    push("stp_halt_nmi", O_HALT, 8'd1);
    cyc();
    fetch(8'h00);
    push("stp_fb", O_FB, 8'd0);     push("stp_halt_irq", O_HALT, 8'd1);
    cyc();
    reset = 1'b1; sync = 1'b0; nmi = 1'b0; irq = 1'b0;
    push("stp_rst_vec", O_VEC, 8'hFC); push("stp_rst_wm", O_WM, 8'd1);
    cyc();
    reset = 1'b0;
    push("stp_rst_halt", O_HALT, 8'd0); push("stp_rst_src", O_SRC, 8'd3);
    push("stp_rst_vec2", O_VEC, 8'hFC);
    cyc();
    fetch(8'hA9);
    push("stp_rseq_fb", O_FB, 8'd1);
    cyc();
    finish_seq("stp_rseq");
    fetch(8'hEA);
    push("stp_nmi_flushed_fb", O_FB, 8'd0);
    cyc();

    // NMI edge inside an IRQ sequence with rdy toggling
    irq = 1'b1; I = 1'b0;
    push("seqnmi_irq_fb", O_FB, 8'd1);
    cyc();
    irq = 1'b0; sync = 1'b0; nmi = 1'b1;
    push("seqnmi_src", O_SRC, 8'd1);
    cyc();
    rdy = 1'b0; vec_done = 1'b1; fetch(8'hEA);
    push("seqnmi_rdy0_fb", O_FB, 8'd0);
    cyc();
    rdy = 1'b1; sync = 1'b0;
    push("seqnmi_rdy0_si", O_SI, 8'd0); push("seqnmi_vec", O_VEC, 8'hFE);
    cyc();
    vec_done = 1'b0; rdy = 1'b0; fetch(8'hEA);
    push("seqnmi_si", O_SI, 8'd1);   push("seqnmi_rdy0_run_fb", O_FB, 8'd0);
    cyc();
    rdy = 1'b1;
    push("seqnmi_taken_fb", O_FB, 8'd1);
    cyc();
    sync = 1'b0;
    push("seqnmi_src2", O_SRC, 8'd2); push("seqnmi_vec2", O_VEC, 8'hFA);
    cyc();

    // fresh NMI edge inside the sequence, then reset mid-sequence
    nmi = 1'b0;
    cyc();
    nmi = 1'b1;
    cyc();
    reset = 1'b1; vec_done = 1'b1; nmi = 1'b0;
    push("midrst_vec", O_VEC, 8'hFC); push("midrst_wm", O_WM, 8'd1);
    push("midrst_fb", O_FB, 8'd0);
    cyc();
    reset = 1'b0; vec_done = 1'b0;
    push("midrst_si", O_SI, 8'd0);    push("midrst_cd", O_CD, 8'd0);
    push("midrst_src", O_SRC, 8'd3);
    cyc();
    push("midrst_si2", O_SI, 8'd0);
    I = 1'b1;
    fetch(8'hA9);
    push("midrst_rseq_fb", O_FB, 8'd1);
    cyc();
    finish_seq("midrst");
    fetch(8'hEA);
    push("midrst_nmi_flushed_fb", O_FB, 8'd0);
    cyc();
    sync = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_ctl.md
# int_ctl

Interrupt, reset and halt sequencer for the 65C02 core. It sits beside `ctl` on the opcode-fetch path and arbitrates between reset, NMI, IRQ and BRK. For hardware sources it forces a BRK opcode into the `ctl` decoder, and it supplies the vector, the B bit and the write-suppress control that the BRK sequence needs. It also implements the WAI and STP halt states.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rdy`  in  1  core advance enable; qualifies `sync` and `vec_done`.
- `sync`  in  1  opcode fetch cycle from `ctl`.
- `DB`  in  8  data bus; holds the opcode while `sync` is high.
- `nmi`  in  1  NMI request, active-high, rising-edge sensitive.
- `irq`  in  1  IRQ request, active-high, level sensitive.
- `I`  in  1  interrupt disable flag.
- `vec_done`  in  1  one-cycle pulse when the vector high byte is fetched (last BRK-sequence cycle).
- `force_brk`  out  1  replace the opcode seen by the `ctl` decoder with 8'h00.
- `vector`  out  8  vector low byte: 8'hFA (NMI), 8'hFC (reset), 8'hFE (IRQ/BRK).
- `B`  out  1  B bit written into pushed P.
- `we_mask`  out  1  suppress core writes (reset pushes become reads).
- `set_i`  out  1  one-cycle pulse: set I.
- `clr_d`  out  1  one-cycle pulse: clear D.
- `halt`  out  1  freeze the core (WAI/STP).
- `int_src`  out  2  latched source: 0 BRK, 1 IRQ, 2 NMI, 3 reset.

## Operation
- States: RST, RUN, SEQ, WAIT, STOP.
- `acc = sync & rdy`.
- NMI edge detect:
  - `nmi1 <= nmi` every cycle, independent of `rdy`.
  - `nmi_pend` is set on `nmi & ~nmi1` and cleared when NMI is selected.
  - Set wins over clear in the same cycle.
- RST: entered from any state while `reset` is high.
  - `reset` clears `nmi_pend` and `nmi1`, and aborts any sequence.
  - At the first `acc`: select reset, `force_brk=1`, go to SEQ.
- RUN, at `acc`, the first match in priority order wins:
  1. `nmi_pend`: select NMI, `force_brk=1`.
  2. `irq & ~I`: select IRQ, `force_brk=1`.
  3. `DB==8'h00`: select BRK, `force_brk=0`.
  4. `DB==8'hCB` (WAI): go to WAIT.
  5. `DB==8'hDB` (STP): go to STOP.
  6. Any other opcode: stay in RUN.
- A selection latches `int_src` and moves to SEQ. `force_brk` is combinational and high only in the `acc` cycle.
- SEQ:
  - `vector`, `B` and `we_mask` are decoded from `int_src`.
  - `B=1` only for BRK; `we_mask=1` only for reset.
  - On `vec_done & rdy`: pulse `set_i` and `clr_d` (all sources), then go to RUN.
  - `sync` during SEQ is ignored.
  - No NMI hijack: an NMI edge during SEQ stays pending and is taken at the first `acc` in RUN.
- WAIT:
  - `halt=1`.
  - Exit to RUN on `nmi_pend | irq`, regardless of `I`.
  - The pending source is then arbitrated at the next `acc` as in RUN. With `I=1` and no NMI, execution continues with no interrupt taken.
- STOP: `halt=1`; only `reset` exits.
- Outputs outside SEQ:
  - RST: `vector=8'hFC`, `B=0`, `we_mask=1`, `int_src=3`.
  - RUN/WAIT/STOP: `vector=8'hFE`, `B=0`, `we_mask=0`; `int_src` holds its last value.

## Timing
- Reset values (registered outputs and state, with `reset` high):
  - state RST, `int_src=3`, `halt=0`.
  - `set_i=0`, `clr_d=0`, `nmi_pend=0`.
- Combinational outputs with `reset` high:
  - `force_brk=0`, `vector=8'hFC`, `B=0`, `we_mask=1`.
- `halt` is registered:
  - Rises the cycle after the WAI/STP `acc`.
  - Falls in the cycle after the wake condition, together with the WAIT→RUN transition.
- NMI latency: the edge is seen at `clk` N; `nmi_pend` is high from N+1. An `acc` in cycle N+1 or later selects it.
- IRQ is sampled only at `acc` (RUN) or every cycle (WAIT); it is not latched.
- `set_i` and `clr_d` are registered: high exactly in the cycle after `vec_done & rdy`.
- `rdy=0`: `acc` and `vec_done` are ignored, state holds, NMI edge detection continues.
- `reset` mid-SEQ: next cycle RST, the SEQ→RUN transition is dropped, and no `set_i`/`clr_d` pulse follows.

## Test plan
- Reset release, first `sync` with `DB=8'hA9` → `force_brk=1`, `int_src=3`, `vector=8'hFC`, `we_mask=1`. `vec_done` → `set_i`/`clr_d` pulse next cycle; state RUN, `we_mask=0`.
- `irq=1`, `I=0`, `nmi` rising edge one cycle before `acc` → NMI selected, `vector=8'hFA`, `nmi_pend` cleared. At the next `acc` after `vec_done`, IRQ is selected: `vector=8'hFE`, `B=0`.
- `DB=8'h00` at `acc`, no requests → `force_brk=0`, `int_src=0`, `B=1`, `vector=8'hFE`. The same with `irq=1`, `I=0` → IRQ wins, `B=0`.
- WAI (`DB=8'hCB`) with `I=1` → `halt=1`. Raise `irq` → `halt=0` next cycle; next `acc` is not forced. Repeat with `I=0` → forced, `int_src=1`.
- STP (`DB=8'hDB`) → `halt=1`, unaffected by `nmi` edges and `irq`. `reset` pulse → `halt=0`, state RST.
- NMI edge in SEQ (IRQ) with `rdy` toggling → pending is kept and taken at the first RUN `acc`. `reset` asserted mid-SEQ → no `set_i` pulse, `nmi_pend=0`.
